addsub_serial: RTL
==================

# addsub_serial

Parametrised, multi-cycle add/subtract unit for the datapath ALU; successor to the single-cycle 32-bit subtractor. It processes DIGIT bits per clock through a ripple slice, trading latency for area. A start/busy/done handshake lets the control unit launch an operation and wait for completion. It produces sum/difference, carry/borrow-out and optional condition flags for the CPU's branch logic.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 8: bits processed per clock; must satisfy 1 ≤ DIGIT ≤ WIDTH.
- clock  in  1  single clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- start  in  1  launch request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract; latched with the operands.
- cin  in  1  carry-in when adding, borrow-in when subtracting; latched.
- Ra  in  WIDTH  operand A; latched on start.
- Rb  in  WIDTH  operand B; latched on start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result register; held until the next completion.
- cout  out  1  carry-out (add) or NOT borrow-out (subtract).
- zero, neg, ovf  out  1 each  condition flags; see Configuration.

## Operation
- N = WIDTH/DIGIT. States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches the operands and mode into internal registers:
    - opA = Ra.
    - opB = sub ? ~Rb : Rb.
    - carry = sub ? ~cin : cin.
  - Clears the digit counter and moves to RUN.
  - start=0 stays in IDLE.
- RUN, one edge per digit i (counter 0..N-1):
  - Computes {c, s} = opA[i] + opB[i] + carry over DIGIT bits.
  - Writes s into the partial-result slice i and updates carry = c.
  - On digit N-1, the final carry and partial result are copied to cout and sum, flags are computed, and the state moves to DONE.
- DONE:
  - done=1 for this one cycle; returns to IDLE on the next edge.
  - A start in DONE is ignored; the next start is accepted in IDLE.
- Arithmetic: sum = (Ra + Rb + cin) mod 2^WIDTH for add, and (Ra − Rb − cin) mod 2^WIDTH for subtract.
  - cout=0 on subtract means a borrow occurred.
- start while busy: ignored; in-flight operands are unaffected.
- Input changes after the start edge have no effect.

## Timing
- Reset: clear=1 at an edge forces the following, regardless of state:
  - State IDLE, counter 0.
  - busy=0, done=0.
  - sum=0, cout=0, zero=0, neg=0, ovf=0.
- A clear during RUN aborts the operation; no done is produced.
- Latency: start sampled at edge E; busy=1 from E through E+N. sum, cout and flags update and done rises at edge E+N; done falls at E+N+1.
- Back-to-back throughput: one operation per N+2 cycles (start re-sampled at E+N+2 at earliest).
- sum, cout and flags change only at completion or clear.

## Configuration
- ADDSUB_FLAGS_EN defined:
  - zero = (sum == 0).
  - neg = sum[WIDTH-1].
  - ovf = carry into MSB XOR carry out of MSB (two's-complement overflow).
  - All three are registered at completion.
- ADDSUB_FLAGS_EN undefined: zero, neg and ovf are tied to 0 and no flag logic is synthesised. sum, cout and timing are identical.

## Test plan
(WIDTH=32, DIGIT=8, N=4, ADDSUB_FLAGS_EN defined unless noted.)
- Subtract Ra=1, Rb=1, cin=0 -> done 4 edges after the start edge; sum=0, cout=1, zero=1, neg=0, ovf=0.
- Subtract Ra=20, Rb=25, cin=0 -> sum=0xFFFFFFFB, cout=0, neg=1, zero=0; busy high for exactly 4 cycles.
- Add Ra=0x7FFFFFFF, Rb=1, cin=0 -> sum=0x80000000, ovf=1, neg=1, cout=0. Add Ra=0xFFFFFFFF, Rb=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0.
- Start Ra=235, Rb=35 subtract, then pulse start with Ra=1, Rb=2 during RUN -> sum=200, single done pulse; second request ignored; sum holds 200 until the next operation.
- Assert clear on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, all flags 0; no done pulse follows. A fresh start then completes normally.
- Build without ADDSUB_FLAGS_EN, subtract 20−25 -> sum=0xFFFFFFFB, cout=0, zero=neg=ovf=0.

Source files
------------

// File: rtl/addsub_serial_if.sv
// Launch/result bundle between the control unit and the serial add/subtract unit.
// Latency: none (wires only).
// Backpressure: start is accepted only while the unit is idle; busy/done report progress.
interface addsub_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] Ra;
  logic [WIDTH-1:0] Rb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  // control unit side: issues operations, observes results
  modport master (
    output start, sub, cin, Ra, Rb,
    input  busy, done, sum, cout, zero, neg, ovf
  );

  // arithmetic unit side
  modport slave (
    input  start, sub, cin, Ra, Rb,
    output busy, done, sum, cout, zero, neg, ovf
  );
endinterface

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract, DIGIT bits per clock through one ripple slice; optional flags via ADDSUB_FLAGS_EN.
// Latency: start sampled at edge E, result/flags/done at edge E+N (N = WIDTH/DIGIT), done drops at E+N+1.
// Backpressure: start is ignored unless IDLE; one operation per N+2 cycles at best.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic           clock,
  input  logic           clear,
  addsub_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // one ripple slice over the lowest digit of the shifting operands
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  assign dsum    = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  // new digit enters at the top; after N steps digit 0 sits at the bottom
  assign acc_nxt = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
  assign last    = (cnt == CW'(N - 1));

  // state register
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // operand latch, digit-serial datapath and result registers
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // subtract as A + ~B + ~borrow_in
            opa   <= bus.Ra;
            opb   <= bus.sub ? ~bus.Rb : bus.Rb;
            carry <= bus.sub ? ~bus.cin : bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          acc   <= acc_nxt;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= acc_nxt;
            cout_q <= dsum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef ADDSUB_FLAGS_EN
  logic zero_q;
  logic neg_q;
  logic ovf_q;
  logic c_into_msb;

  // carry into the MSB recovered from the MSB sum bit and its two inputs
  assign c_into_msb = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];

  // condition flags captured together with the result
  always_ff @(posedge clock) begin
    if (clear) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == RUN && last) begin
      zero_q <= (acc_nxt == '0);
      neg_q  <= acc_nxt[WIDTH-1];
      ovf_q  <= c_into_msb ^ dsum[DIGIT];
    end
  end

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.neg  = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

endmodule
